ifmap_multicast_ctrl: RTL and testbench
=======================================

# ifmap_multicast_ctrl

Per-PE multicast controller on the ifmap/filter/ipsum global input bus, directly upstream of a PE wrapper. It compares the bus tag against a configured PE ID, captures matching transfers into a small FIFO, and presents them to the PE in the packed `{enable, data}` format with ready/enable handshaking. Non-matching transfers are acknowledged without capture, so one slow PE only stalls the bus for data addressed to it.

## Interface
- DATA_SIZE, 8, bits per data word
- DATA_NUM, 1, words per transfer (1 for ifmap/ipsum, 4 for filter)
- ID_BIT, 5, tag/ID width
- FIFO_DEPTH, 2, entries; power of two, ≥2
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- set_id  in  1  load `id_in` into ID register this cycle
- id_in  in  ID_BIT  PE ID value to configure
- tag_in  in  ID_BIT  destination tag of current bus transfer
- bus_in  in  DATA_NUM*DATA_SIZE+1  `{enable, data}`, enable is MSB
- bus_ready  out  1  bus transfer may complete this cycle
- pe_out  out  DATA_NUM*DATA_SIZE+1  `{enable, data}` to PE, enable is MSB
- pe_ready  in  1  PE accepts `pe_out` this cycle

## Operation
- ID register `id_q` and flag `id_valid` are set on `set_id`. The new ID takes effect the following cycle. Reconfiguring mid-stream keeps FIFO contents.
- match = id_valid & ((tag_in == id_q) | (tag_in == all-ones)). All-ones is broadcast.
- bus_ready = !match | !full. Combinational from tag_in, id state and the FIFO count.
- push = bus_in enable & match & !full. Non-matching enabled transfers are dropped and acknowledged.
- pe_out enable = !empty. pe_out data = FIFO head when non-empty, else all-zero.
- pop = !empty & pe_ready.
- Push and pop in the same cycle:
  - Allowed when not full; count is unchanged.
  - When full, push is refused even if a pop occurs that cycle. There is no full-bypass, so bus_ready stays a function of registered state plus tag.
- There is no empty-bypass. Data never passes through combinationally.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- Internal status (not a port): EMPTY (count 0), PARTIAL, FULL (count = FIFO_DEPTH). Transitions:
  - EMPTY→PARTIAL on push without pop.
  - PARTIAL→FULL on push without pop at count FIFO_DEPTH-1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop without push at count 1.
  - All other cases hold state.
- Reset:
  - id_q=0, id_valid=0, pointers and count 0.
  - pe_out=0. bus_ready=1, since nothing matches before configuration.
  - Reset mid-operation discards FIFO contents and ID, with no partial output.
- set_id and rst in the same cycle: rst wins.

## Timing
- Latency: transfer accepted at edge N appears on pe_out with enable=1 in cycle N+1.
- Throughput: 1 transfer/cycle sustained when pe_ready is held high.
- A transfer completes on a clock edge where bus_in enable & bus_ready.
- A PE transfer completes on an edge where pe_out enable & pe_ready.
- pe_out holds stable (enable and data) until it is accepted.
- bus_ready may fall in the same cycle tag_in changes to a matching ID while full. The bus must sample it combinationally (AND across all controllers).
- First transfer after set_id at edge N may be accepted at edge N+1.

## Structure
- Shared package/header: BROADCAST_TAG (all-ones of ID_BIT), enable-bit index macros for the packed `{enable,data}` format.
- These index macros are reused from the PE wrapper side so the packing stays identical.
- One sub-module: `mc_sync_fifo` (parameters WIDTH, DEPTH; push, pop, full, empty, head, sync active-high reset).
- Tag compare, ID register and handshake logic live in the top.

## Test plan
1. Config and single transfer:
   - Reset, then set_id with id_in=5.
   - Next cycle: tag_in=5, bus_in={1,8'hA3}, pe_ready=1.
   - Expect bus_ready=1, then pe_out={1,8'hA3} the following cycle, then pe_out=0.
2. Mismatch and unconfigured drop:
   - Before any set_id, send tag 5 → bus_ready=1, pe_out enable never rises.
   - After id=5, send tag 7 → dropped, bus_ready=1.
3. Broadcast: id=3, tag=5'h1F, data 8'h11 → captured, pe_out={1,8'h11}.
4. Backpressure/full:
   - id=2, pe_ready=0, push 8'h01, 8'h02.
   - Expect bus_ready=0 for tag 2 on the third cycle, but bus_ready=1 for tag 4 that cycle.
   - Raise pe_ready: outputs 01 then 02 in order. bus_ready for tag 2 rises the cycle after the first pop.
5. Streaming wrap: pe_ready=1, 10 consecutive matching words 0..9 → pe_out shows 0..9 on consecutive cycles, one cycle delayed, with no gaps or duplicates.
6. Reset mid-stream: FIFO holding 2 entries, assert rst for one cycle → next cycle pe_out=0, bus_ready=1, id_valid=0 (tag 2 no longer captured).

Source files
------------

// File: rtl/ifmap_multicast_ctrl_pkg.sv
// Shared definitions for the ifmap/filter/ipsum multicast controller and the
// PE wrapper that consumes its packed {enable, data} output.
package ifmap_multicast_ctrl_pkg;

  // Default tag width; broadcast is the all-ones tag of that width.
  localparam int DEF_ID_BIT = 5;
  localparam logic [DEF_ID_BIT-1:0] BROADCAST_TAG = '1;

  // Occupancy status of the capture FIFO.
  typedef enum logic [1:0] {
    FS_EMPTY   = 2'd0,
    FS_PARTIAL = 2'd1,
    FS_FULL    = 2'd2
  } fifo_state_e;

  // Enable bit sits directly above the data words in the packed bus format.
  function automatic int pk_en_idx(input int data_num, input int data_size);
    return data_num * data_size;
  endfunction

  // Width of the data portion (everything below the enable bit).
  function automatic int pk_data_w(input int data_num, input int data_size);
    return data_num * data_size;
  endfunction

endpackage

// File: rtl/ifmap_multicast_ctrl_if.sv
// Bus/PE-side handshake bundle for one multicast controller.
// master: global bus + config source and PE sink; slave: the controller.
interface ifmap_multicast_ctrl_if #(
  parameter int DATA_SIZE = 8,
  parameter int DATA_NUM  = 1,
  parameter int ID_BIT    = 5
) ();
  logic                            set_id;
  logic [ID_BIT-1:0]               id_in;
  logic [ID_BIT-1:0]               tag_in;
  logic [DATA_NUM*DATA_SIZE:0]     bus_in;
  logic                            bus_ready;
  logic [DATA_NUM*DATA_SIZE:0]     pe_out;
  logic                            pe_ready;

  modport master (
    output set_id, id_in, tag_in, bus_in, pe_ready,
    input  bus_ready, pe_out
  );

  modport slave (
    input  set_id, id_in, tag_in, bus_in, pe_ready,
    output bus_ready, pe_out
  );
endinterface

// File: rtl/ifmap_multicast_ctrl_mc_sync_fifo.sv
// Small synchronous FIFO with a registered EMPTY/PARTIAL/FULL status.
// No bypass in either direction: a push while full is refused even if a pop
// happens the same cycle, and data written this cycle is visible next cycle.
module mc_sync_fifo
  import ifmap_multicast_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  fifo_state_e      state_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (state_q != FS_FULL);
  assign do_pop  = pop_i && (state_q != FS_EMPTY);
  assign full_o  = (state_q == FS_FULL);
  assign empty_o = (state_q == FS_EMPTY);
  assign head_o  = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers, count and occupancy status.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= FS_EMPTY;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop) count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
      case (state_q)
        FS_EMPTY:   if (do_push) state_q <= FS_PARTIAL;
        FS_PARTIAL: begin
          if (do_push && !do_pop && count_q == CNT_LAST) state_q <= FS_FULL;
          else if (do_pop && !do_push && count_q == CNT_ONE) state_q <= FS_EMPTY;
        end
        FS_FULL:    if (do_pop) state_q <= FS_PARTIAL;
        default:    state_q <= FS_EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/ifmap_multicast_ctrl.sv
// Per-PE multicast controller: captures bus transfers whose tag matches the
// configured PE ID (or the broadcast tag) and hands them to the PE.
// Non-matching transfers are acknowledged immediately and dropped.
module ifmap_multicast_ctrl
  import ifmap_multicast_ctrl_pkg::*;
#(
  parameter int DATA_SIZE  = 8,
  parameter int DATA_NUM   = 1,
  parameter int ID_BIT     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input logic                   clk,
  input logic                   rst,
  ifmap_multicast_ctrl_if.slave bus_if
);
  localparam int EN_IDX = pk_en_idx(DATA_NUM, DATA_SIZE);
  localparam int DW     = pk_data_w(DATA_NUM, DATA_SIZE);

  logic [ID_BIT-1:0] id_q;
  logic              id_valid_q;
  logic              match, full, empty, push, pop;
  logic [DW-1:0]     head;

  // ID register; reset dominates a simultaneous set_id.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q       <= '0;
      id_valid_q <= 1'b0;
    end else if (bus_if.set_id) begin
      id_q       <= bus_if.id_in;
      id_valid_q <= 1'b1;
    end
  end

  // bus_ready depends only on registered state plus tag, so every controller's
  // ready can be ANDed combinationally on the shared bus.
  assign match = id_valid_q &&
                 ((bus_if.tag_in == id_q) || (bus_if.tag_in == {ID_BIT{1'b1}}));
  assign bus_if.bus_ready = !match || !full;
  assign push = bus_if.bus_in[EN_IDX] && match && !full;
  assign pop  = !empty && bus_if.pe_ready;
  assign bus_if.pe_out = empty ? '0 : {1'b1, head};

  mc_sync_fifo #(
    .WIDTH(DW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .wdata_i(bus_if.bus_in[DW-1:0]),
    .pop_i  (pop),
    .full_o (full),
    .empty_o(empty),
    .head_o (head)
  );
endmodule

// File: tb/tb_ifmap_multicast_ctrl.sv
// Bench for ifmap_multicast_ctrl: directed scenarios then random traffic,
// all compared against a queue-based model of the controller's behaviour.
module tb_ifmap_multicast_ctrl;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  logic [4:0] m_id;
  bit         m_valid;
  logic [7:0] m_q[$];

  logic       o_rdy;
  logic [8:0] o_pe;

  ifmap_multicast_ctrl_if #(.DATA_SIZE(8), .DATA_NUM(1), .ID_BIT(5)) ifc ();

  ifmap_multicast_ctrl #(
    .DATA_SIZE(8), .DATA_NUM(1), .ID_BIT(5), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_if(ifc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs, check outputs against the model, then
  // advance the model across the clock edge.
  task automatic step(input bit r, input bit sid, input logic [4:0] idv,
                      input logic [4:0] tg, input bit en, input logic [7:0] d,
                      input bit pr, output logic obs_rdy, output logic [8:0] obs_pe);
    bit         mt, full, dpush, dpop;
    logic       e_rdy;
    logic [8:0] e_pe;
    @(negedge clk);
    rst = r;
    ifc.set_id = sid; ifc.id_in = idv; ifc.tag_in = tg;
    ifc.bus_in = {en, d}; ifc.pe_ready = pr;
    #1;
    mt    = m_valid && (tg == m_id || tg == 5'h1F);
    full  = (m_q.size() == DEPTH);
    e_rdy = !(mt && full);
    e_pe  = (m_q.size() > 0) ? {1'b1, m_q[0]} : 9'h0;
    obs_rdy = ifc.bus_ready;
    obs_pe  = ifc.pe_out;
    chk("bus_ready", {15'h0, obs_rdy}, {15'h0, e_rdy});
    chk("pe_out", {7'h0, obs_pe}, {7'h0, e_pe});
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_valid = 0;
      m_id = '0;
    end else begin
      dpush = en && mt && !full;
      dpop  = (m_q.size() > 0) && pr;
      if (dpop) void'(m_q.pop_front());
      if (dpush) m_q.push_back(d);
      if (sid) begin
        m_id = idv;
        m_valid = 1;
      end
    end
  endtask

  task automatic idle(input bit pr);
    step(0, 0, 5'd0, 5'd0, 0, 8'h00, pr, o_rdy, o_pe);
  endtask

  initial begin
    rst = 1'b1;
    ifc.set_id = 0; ifc.id_in = '0; ifc.tag_in = '0; ifc.bus_in = '0; ifc.pe_ready = 0;
    m_id = '0; m_valid = 0;

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, o_rdy, o_pe);
    idle(0);
    chk("reset_pe_out", {7'h0, o_pe}, 16'h0);
    chk("reset_bus_ready", {15'h0, o_rdy}, 16'h1);

    // 1: configure id 5, single transfer
    step(0, 1, 5'd5, 0, 0, 0, 1, o_rdy, o_pe);
    step(0, 0, 0, 5'd5, 1, 8'hA3, 1, o_rdy, o_pe);
    chk("t1_ready", {15'h0, o_rdy}, 16'h1);
    idle(1);
    chk("t1_out", {7'h0, o_pe}, 16'h1A3);
    idle(1);
    chk("t1_drained", {7'h0, o_pe}, 16'h0);

    // 2: unconfigured drop, then mismatch drop
    step(1, 0, 0, 0, 0, 0, 1, o_rdy, o_pe);
    step(0, 0, 0, 5'd5, 1, 8'h55, 1, o_rdy, o_pe);
    chk("t2_unconf_ready", {15'h0, o_rdy}, 16'h1);
    idle(1);
    chk("t2_unconf_out", {7'h0, o_pe}, 16'h0);
    step(0, 1, 5'd5, 0, 0, 0, 1, o_rdy, o_pe);
    step(0, 0, 0, 5'd7, 1, 8'h66, 1, o_rdy, o_pe);
    chk("t2_mismatch_ready", {15'h0, o_rdy}, 16'h1);
    idle(1);
    chk("t2_mismatch_out", {7'h0, o_pe}, 16'h0);

    // 3: broadcast
    step(0, 1, 5'd3, 0, 0, 0, 1, o_rdy, o_pe);
    step(0, 0, 0, 5'h1F, 1, 8'h11, 1, o_rdy, o_pe);
    idle(1);
    chk("t3_bcast_out", {7'h0, o_pe}, 16'h111);

    // 4: backpressure to full, then drain in order
    step(0, 1, 5'd2, 0, 0, 0, 0, o_rdy, o_pe);
    step(0, 0, 0, 5'd2, 1, 8'h01, 0, o_rdy, o_pe);
    step(0, 0, 0, 5'd2, 1, 8'h02, 0, o_rdy, o_pe);
    step(0, 0, 0, 5'd4, 1, 8'h09, 0, o_rdy, o_pe);
    chk("t4_other_tag_ready", {15'h0, o_rdy}, 16'h1);
    step(0, 0, 0, 5'd2, 1, 8'h03, 0, o_rdy, o_pe);
    chk("t4_full_ready", {15'h0, o_rdy}, 16'h0);
    step(0, 0, 0, 5'd2, 0, 8'h00, 1, o_rdy, o_pe);
    chk("t4_first", {7'h0, o_pe}, 16'h101);
    chk("t4_ready_still_low", {15'h0, o_rdy}, 16'h0);
    step(0, 0, 0, 5'd2, 0, 8'h00, 1, o_rdy, o_pe);
    chk("t4_second", {7'h0, o_pe}, 16'h102);
    chk("t4_ready_back", {15'h0, o_rdy}, 16'h1);
    idle(1);
    chk("t4_empty", {7'h0, o_pe}, 16'h0);

    // 5: streaming through pointer wrap
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 5'd2, 1, 8'(i), 1, o_rdy, o_pe);
      chk("t5_ready", {15'h0, o_rdy}, 16'h1);
      if (i > 0) chk("t5_stream", {7'h0, o_pe}, {7'h0, 1'b1, 8'(i - 1)});
    end
    idle(1);
    chk("t5_last", {7'h0, o_pe}, 16'h109);

    // 6: reset with two entries held; rst together with set_id loses set_id
    step(0, 0, 0, 5'd2, 1, 8'hC1, 0, o_rdy, o_pe);
    step(0, 0, 0, 5'd2, 1, 8'hC2, 0, o_rdy, o_pe);
    step(1, 1, 5'd2, 5'd2, 0, 8'h00, 0, o_rdy, o_pe);
    step(0, 0, 0, 5'd2, 1, 8'hC3, 0, o_rdy, o_pe);
    chk("t6_pe_cleared", {7'h0, o_pe}, 16'h0);
    chk("t6_ready", {15'h0, o_rdy}, 16'h1);
    idle(0);
    chk("t6_no_capture", {7'h0, o_pe}, 16'h0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      bit         r, sid, en, pr;
      logic [4:0] tg, idv;
      r   = ($urandom_range(0, 199) == 0);
      sid = ($urandom_range(0, 29) == 0);
      idv = 5'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       tg = 5'h1F;
        1:       tg = 5'($urandom);
        default: tg = 5'($urandom_range(0, 3));
      endcase
      en = ($urandom_range(0, 3) != 0);
      pr = ($urandom_range(0, 2) != 0);
      step(r, sid, idv, tg, en, 8'($urandom), pr, o_rdy, o_pe);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
